// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: data width, op-code constants,
// FSM state encoding and the op legality decode.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_PASSB = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for every op code the ALU implements; anything else is flagged illegal.
    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_PASSB: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arb_if.sv
// Bundle of the two requester channels, the response channel and busy.
// master = requesters/response consumer side, slave = the alu_arb block.
interface alu_arb_if;
    import alu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_illegal;

    logic              busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal,
        output busy
    );

endinterface

// File: rtl/alu.sv
// Purely combinational 32-bit ALU. Unknown op codes produce zero; legality
// is judged by the caller.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    // Op select; ADD/SUB wrap naturally, SLT is an unsigned compare.
    always_comb begin
        result = '0;
        case (op)
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_SLT:   result = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_PASSB: result = b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a single shared ALU.
// IDLE -> EXEC (operands registered) -> RESP (result held until accepted).
// A new request may be accepted in RESP on the same cycle the response is taken.
module alu_arb
    import alu_pkg::*;
#(
    parameter logic RR_INIT = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_arb_if.slave bus
);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              id_q, id_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_illegal_q, rsp_illegal_d;

    logic              can_accept;
    logic              accept;
    logic              grant;
    logic              op_legal;
    logic [DATA_W-1:0] alu_result;

    alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    // Arbitration and ready: combinational from valids, state and rsp_ready only.
    always_comb begin
        can_accept = (state_q == ST_IDLE) ||
                     ((state_q == ST_RESP) && bus.rsp_ready);
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus.req1_valid;
        end
        accept         = can_accept && (bus.req0_valid || bus.req1_valid);
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept && grant;
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        id_d          = id_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        op_legal      = op_is_legal(op_q);

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // Illegal ops force a zero result with the zero flag clear.
                rsp_result_d  = op_legal ? alu_result : '0;
                rsp_zero_d    = op_legal && (alu_result == '0);
                rsp_illegal_d = !op_legal;
                rsp_id_d      = id_q;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            op_d         = grant ? bus.req1_op : bus.req0_op;
            a_d          = grant ? bus.req1_a  : bus.req0_a;
            b_d          = grant ? bus.req1_b  : bus.req0_b;
            id_d         = grant;
            last_grant_d = grant;
        end
    end

    // FSM and all datapath registers; async reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= RR_INIT;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            id_q          <= id_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    // Response outputs come straight from registers.
    always_comb begin
        bus.rsp_valid   = (state_q == ST_RESP);
        bus.busy        = (state_q != ST_IDLE);
        bus.rsp_id      = rsp_id_q;
        bus.rsp_result  = rsp_result_q;
        bus.rsp_zero    = rsp_zero_q;
        bus.rsp_illegal = rsp_illegal_q;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: RR_INIT, 1'b1, initial value of the last-grant register; 1 gives requester 0 the first contested grant.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester n's operation accepted this cycle (valid&ready).
REQ-006 req0_op / req1_op  input  4  ALU select: 0000 AND, 0001 OR, 0010 ADD, 0100 SUB, 1000 SLT (unsigned, result 1/0), 1001 pass B.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  32 each  operands A and B.
REQ-008 rsp_valid  output  1  response held valid until accepted.
REQ-009 rsp_ready  input  1  response consumer accepts.
REQ-010 rsp_id  output  1  index of the requester that owns the response.
REQ-011 rsp_result  output  32  ALU result.
REQ-012 rsp_zero  output  1  ALU zero flag for rsp_result.
REQ-013 rsp_illegal  output  1  op code not in REQ-006 list.
REQ-014 busy  output  1  high in EXEC or RESP state.

Function
REQ-015 States IDLE, EXEC, RESP; single shared ALU instance, never used by two requests at once.
REQ-016 Accept is permitted in IDLE, or in RESP in the same cycle as rsp_valid&rsp_ready; at most one ready asserted per cycle; ready is combinational from valid and state, never asserted without its valid.
REQ-017 Arbitration: one valid -> grant it; both valid -> grant the requester not equal to last_grant; last_grant updates only on accept.
REQ-018 On accept: latch op, A, B, id into operand registers; next state EXEC.
REQ-019 EXEC: ALU driven from operand registers; result, zero flag, illegal flag, id registered into response registers at end of cycle; next state RESP.
REQ-020 RESP: rsp_valid=1, all rsp_* stable until handshake; on handshake with no accept -> IDLE; with accept -> EXEC.
REQ-021 Latency: accept in cycle N -> rsp_valid rises in cycle N+2; sustained throughput one op per 2 cycles with rsp_ready held high.
REQ-022 Illegal op: rsp_result=0, rsp_zero=0, rsp_illegal=1; ALU output ignored; handshake otherwise identical.
REQ-023 ADD/SUB wrap modulo 2^32, no overflow output; SLT unsigned 32-bit compare.
REQ-024 rsp_zero=1 exactly when rsp_result==0 for legal ops.
REQ-025 rsp_ready high with rsp_valid low is ignored; requester valid dropped before accept is legal and causes no grant.
REQ-026 No combinational path from rsp_ready to rsp_* data; rsp_ready to req*_ready path permitted.

Reset
REQ-027 Asserting rst_n low forces IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, busy=0, last_grant=RR_INIT, operand registers=0, immediately and independent of clk.
REQ-028 Reset mid-EXEC or mid-RESP discards the in-flight operation; no response issued after release.
REQ-029 First accept possible in the first clk edge after rst_n deasserts.

Structure
REQ-030 Op-code constants (AND, OR, ADD, SUB, SLT, PASSB) and state encoding live in shared package alu_pkg.
REQ-031 One sub-module: the existing alu, instantiated once; legality decode and arbitration inside alu_arb.

Verification
REQ-032 Reset, req0 ADD A=5 B=7, rsp_ready=1 -> rsp_valid at accept+2, result 12, zero 0, id 0, illegal 0.
REQ-033 Both valid every cycle, rsp_ready=1, RR_INIT=1 -> grants 0,1,0,1..., one response per 2 cycles, ids alternate.
REQ-034 req1 SUB A=9 B=9, rsp_ready=0 for 5 cycles -> rsp_valid held, result 0, zero 1, stable; no further ready until handshake.
REQ-035 req0 op 4'b0011 -> result 0, zero 0, illegal 1; next req0 SLT A=1 B=0xFFFFFFFF -> result 1.
REQ-036 ADD A=0xFFFFFFFF B=1 -> result 0, zero 1; PASSB B=0xA5A5A5A5 -> result 0xA5A5A5A5.
REQ-037 rst_n low during EXEC -> rsp_valid 0 immediately, no response after release, next contested grant to requester 0.
